// File: rtl/cpu_alu_decode_pkg.sv
// Shared CPU/ALU definitions: operator codes, opcode field layout and
// a helper telling which operators update the flag registers.
package cpu_alu_decode_pkg;

  localparam int ALU_OP_W = 3;
  localparam int INSN_W   = 8;
  localparam int INSN_X_W = 2;
  localparam int INSN_Y_W = 3;
  localparam int INSN_Z_W = 3;

  // Operator codes shared by the CPU control path and the ALU.
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 3'd5;

  // Split view of an opcode byte: x = [7:6], y = [5:3], z = [2:0].
  typedef struct packed {
    logic [INSN_X_W-1:0] x;
    logic [INSN_Y_W-1:0] y;
    logic [INSN_Z_W-1:0] z;
  } insn_fields_t;

  // Codes 6 and 7 are reserved and behave exactly like NOP, so only
  // ADD..XOR are allowed to load new flag values.
  function automatic logic alu_op_writes_flags(input logic [ALU_OP_W-1:0] op);
    return (op >= ALU_OP_ADD) && (op <= ALU_OP_XOR);
  endfunction

endpackage

// File: rtl/cpu_alu_decode_alu.sv
// ALU: combinational result plus registered zero/carry flags.
// Only DATA_W = 8 is supported.
module alu
  import cpu_alu_decode_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [DATA_W-1:0]   result_o,
  output logic                zero_o,
  output logic                carry_o
);

  logic [DATA_W:0] sum_w;
  logic [DATA_W:0] diff_w;
  logic            zero_cand;
  logic            carry_cand;
  logic            zero_d,  zero_q;
  logic            carry_d, carry_q;

  // Widened add/sub; the extra MSB is the carry out or, for subtraction,
  // the borrow (set exactly when a < b unsigned).
  always_comb begin
    sum_w  = {1'b0, a_i} + {1'b0, b_i};
    diff_w = {1'b0, a_i} - {1'b0, b_i};
  end

  // Result and flag candidates; NOP and reserved codes pass operand a.
  always_comb begin
    result_o   = a_i;
    carry_cand = 1'b0;
    case (op_i)
      ALU_OP_ADD: begin
        result_o   = sum_w[DATA_W-1:0];
        carry_cand = sum_w[DATA_W];
      end
      ALU_OP_SUB: begin
        result_o   = diff_w[DATA_W-1:0];
        carry_cand = diff_w[DATA_W];
      end
      ALU_OP_AND: result_o = a_i & b_i;
      ALU_OP_OR:  result_o = a_i | b_i;
      ALU_OP_XOR: result_o = a_i ^ b_i;
      default:    result_o = a_i;
    endcase
    zero_cand = (result_o == '0);
  end

  // Flags load candidates only for real operations, otherwise hold.
  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    if (alu_op_writes_flags(op_i)) begin
      zero_d  = zero_cand;
      carry_d = carry_cand;
    end
  end

  // Flag registers; synchronous reset wins over a simultaneous update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign zero_o  = zero_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/cpu_alu_decode_decoder.sv
// Opcode field splitter: purely combinational, no clock or reset.
module cpu_decoder
  import cpu_alu_decode_pkg::*;
(
  input  logic [INSN_W-1:0]   insn_i,
  output logic [INSN_X_W-1:0] x_o,
  output logic [INSN_Y_W-1:0] y_o,
  output logic [INSN_Z_W-1:0] z_o
);

  insn_fields_t fields;

  // Reinterpret the byte through the packed struct so the field layout is
  // defined in one place.
  always_comb begin
    fields = insn_fields_t'(insn_i);
    x_o    = fields.x;
    y_o    = fields.y;
    z_o    = fields.z;
  end

endmodule

// File: rtl/cpu_alu_decode.sv
// Top: opcode decoder alongside the ALU with its flag registers.
module cpu_alu_decode
  import cpu_alu_decode_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          insn,
  output logic [1:0]          insn_x,
  output logic [2:0]          insn_y,
  output logic [2:0]          insn_z,
  input  logic [DATA_W-1:0]   operand_a,
  input  logic [DATA_W-1:0]   operand_b,
  input  logic [2:0]          operator,
  output logic [DATA_W-1:0]   result,
  output logic                flag_zero,
  output logic                flag_carry
);

  cpu_decoder u_dec (
    .insn_i (insn),
    .x_o    (insn_x),
    .y_o    (insn_y),
    .z_o    (insn_z)
  );

  alu #(.DATA_W(DATA_W)) u_alu (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_i      (operand_a),
    .b_i      (operand_b),
    .op_i     (operator),
    .result_o (result),
    .zero_o   (flag_zero),
    .carry_o  (flag_carry)
  );

endmodule

// File: tb/tb_cpu_alu_decode.sv
// Directed + randomized bench for cpu_alu_decode against an arithmetic model.
module tb_cpu_alu_decode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] insn;
  logic [1:0] insn_x;
  logic [2:0] insn_y, insn_z;
  logic [7:0] operand_a, operand_b;
  logic [2:0] operator;
  logic [7:0] result;
  logic       flag_zero, flag_carry;

  int n_pass  = 0;
  int n_total = 0;

  // model flag state
  int m_zero  = 0;
  int m_carry = 0;

  cpu_alu_decode #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .insn(insn), .insn_x(insn_x), .insn_y(insn_y),
    .insn_z(insn_z), .operand_a(operand_a), .operand_b(operand_b),
    .operator(operator), .result(result), .flag_zero(flag_zero),
    .flag_carry(flag_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on the operator semantics.
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output int c, output bit upd);
    upd = 1'b1;
    c   = 0;
    case (op)
      1: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      2: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      default: begin r = a; upd = 1'b0; end
    endcase
  endfunction

  // Apply an op, check result combinationally, clock it, update model, check flags.
  task automatic do_op(input string tag, input int op, input int a, input int b);
    int r, c;
    bit upd;
    operator  = op[2:0];
    operand_a = a[7:0];
    operand_b = b[7:0];
    #1;
    ref_alu(op, a, b, r, c, upd);
    check({tag, ".result"}, {24'd0, result}, r);
    @(posedge clk); #1;
    if (!rst_n) begin
      m_zero = 0; m_carry = 0;
    end else if (upd) begin
      m_zero = (r == 0) ? 1 : 0; m_carry = c;
    end
    check({tag, ".zero"},  {31'd0, flag_zero},  m_zero);
    check({tag, ".carry"}, {31'd0, flag_carry}, m_carry);
  endtask

  task automatic check_dec(input string tag, input int v);
    insn = v[7:0];
    #1;
    check({tag, ".x"}, {30'd0, insn_x}, (v / 64) % 4);
    check({tag, ".y"}, {29'd0, insn_y}, (v / 8) % 8);
    check({tag, ".z"}, {29'd0, insn_z}, v % 8);
  endtask

  initial begin
    rst_n = 1'b0; insn = 8'h00;
    operand_a = 8'h00; operand_b = 8'h00; operator = 3'd0;

    // reset state, plus decode stays live during reset
    @(posedge clk); #1;
    check("reset.zero",  {31'd0, flag_zero},  0);
    check("reset.carry", {31'd0, flag_carry}, 0);
    check_dec("dec_in_reset", 8'hA5);
    rst_n = 1'b1;

    check_dec("dec_78", 8'h78);
    check_dec("dec_C3", 8'hC3);
    for (int i = 0; i < 16; i++) check_dec("dec_rand", int'($urandom_range(0, 255)));

    do_op("add_wrap", 1, 8'hFF, 8'h01);
    do_op("sub_5_1", 2, 8'h05, 8'h01);
    do_op("sub_borrow", 2, 8'h00, 8'h01);
    do_op("hold_same", 2, 8'h00, 8'h01);
    do_op("and_zero", 3, 8'hF0, 8'h0F);
    for (int i = 0; i < 3; i++)
      do_op("nop_hold", 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    do_op("rsv6", 6, 8'h00, 8'h33);
    do_op("rsv7", 7, 8'h12, 8'h34);
    do_op("or", 4, 8'hA0, 8'h05);
    do_op("xor_zero", 5, 8'h5A, 8'h5A);

    // reset overrides the pending ADD, then release
    rst_n = 1'b0;
    do_op("rst_add", 1, 8'hFF, 8'h01);
    rst_n = 1'b1;
    do_op("post_rst_add", 1, 8'hFF, 8'h01);

    // random sweep over real operations
    for (int i = 0; i < 256; i++)
      do_op("rand_op", int'($urandom_range(1, 5)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    // mixed sweep including NOP and reserved codes
    for (int i = 0; i < 64; i++)
      do_op("rand_any", int'($urandom_range(0, 7)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
